vt100_tx: RTL and testbench

VT100_TX -- requirements
Module: vt100_tx

---
 rtl/vt100_pkg.sv | 47 ++++
 rtl/vt100_uart_tx.sv | 59 +++++
 rtl/vt100_tx.sv | 157 +++++++++++++++
 tb/tb_vt100_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vt100_pkg.sv
// Shared opcodes, terminal limits and escape-sequence helpers for the VT100 transmitter.
// Decimal conversion is a compare chain so it stays a small combinational cone.
package vt100_pkg;

    typedef enum logic [1:0] {
        OP_CHAR  = 2'd0,
        OP_GOTO  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_COLOR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    localparam logic [7:0] ESC     = 8'h1B;
    localparam int         ROWS    = 30;
    localparam int         COLS    = 80;
    localparam int         SEQ_MAX = 8;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } dec_t;

    typedef struct packed {
        logic [3:0]                  len;
        logic [SEQ_MAX-1:0][7:0]     bytes;
    } seq_t;

    function automatic dec_t to_dec(input logic [6:0] v);
        dec_t r;
        r.tens = 4'd0;
        for (int t = 1; t <= 8; t++) begin
            if (v >= 7'(t * 10)) r.tens = 4'(t);
        end
        r.units = 4'(v - 7'(r.tens) * 7'd10);
        return r;
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

endpackage

// File: rtl/vt100_uart_tx.sv
// 8N1 serializer: start bit appears the cycle after load_vld, each bit held DIV cycles.
// Latency: done pulses in the last cycle of the stop bit, so a load then continues with no gap.
// Backpressure: none; a load always restarts the frame, the caller waits for done.
module vt100_uart_tx #(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_vld,
    input  logic [7:0] byte_dat,
    output logic       done,
    output logic       tx
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic          active_q;
    logic [3:0]    bit_q;
    logic [CW-1:0] cnt_q;
    logic [8:0]    sh_q;
    logic          tx_q;
    logic          bit_end;

    assign bit_end = (cnt_q == CW'(DIV - 1));
    assign done    = active_q && bit_end && (bit_q == 4'd9);
    assign tx      = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            bit_q    <= 4'd0;
            cnt_q    <= '0;
            sh_q     <= '0;
            tx_q     <= 1'b1;
        end else if (load_vld) begin
            active_q <= 1'b1;
            bit_q    <= 4'd0;
            cnt_q    <= '0;
            sh_q     <= {1'b1, byte_dat};
            tx_q     <= 1'b0;
        end else if (active_q) begin
            if (bit_end) begin
                cnt_q <= '0;
                if (bit_q == 4'd9) begin
                    active_q <= 1'b0;
                    tx_q     <= 1'b1;
                end else begin
                    // sh_q carries data LSB first followed by the stop bit
                    bit_q <= bit_q + 4'd1;
                    tx_q  <= sh_q[0];
                    sh_q  <= {1'b1, sh_q[8:1]};
                end
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/vt100_tx.sv
// VT100 command encoder: turns CHAR/GOTO/CLEAR/COLOR commands into escape sequences on a UART.
// Latency: first start bit the cycle after acceptance; bytes of a sequence are back-to-back.
// Backpressure: cmd_ready low from acceptance until the last stop bit completes.
module vt100_tx
    import vt100_pkg::*;
#(
    parameter int CLOCK_FREQ = 62500000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_char,
    input  logic [4:0] cmd_row,
    input  logic [6:0] cmd_col,
    input  logic [2:0] cmd_fg,
    output logic       tx,
    output logic       busy
);

    localparam int DIV = CLOCK_FREQ / BAUD_RATE;

    state_e     state_q, state_d;
    seq_t       seq_d, seq_q;
    logic [3:0] idx_q;
    logic [7:0] nxt_q;
    logic       accept;
    logic       uart_load;
    logic [7:0] uart_byte;
    logic       uart_done;
    logic [4:0] row_c;
    logic [6:0] col_c;
    dec_t       row_dec, col_dec;
    logic [2:0] pos;

    assign accept    = cmd_valid && (state_q == ST_IDLE);
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

    assign row_c   = (cmd_row > 5'(ROWS - 1)) ? 5'(ROWS - 1) : cmd_row;
    assign col_c   = (cmd_col > 7'(COLS - 1)) ? 7'(COLS - 1) : cmd_col;
    assign row_dec = to_dec(7'(row_c) + 7'd1);
    assign col_dec = to_dec(col_c + 7'd1);

    // The whole sequence is built from the live inputs and latched on acceptance.
    always_comb begin
        seq_d = '0;
        pos   = 3'd0;
        case (cmd_op)
            OP_CHAR: begin
                seq_d.bytes[0] = cmd_char;
                seq_d.len      = 4'd1;
            end
            OP_GOTO: begin
                seq_d.bytes[0] = ESC;
                seq_d.bytes[1] = 8'h5B;
                pos            = 3'd2;
                if (row_dec.tens != 4'd0) begin
                    seq_d.bytes[pos] = ascii_digit(row_dec.tens);
                    pos              = pos + 3'd1;
                end
                seq_d.bytes[pos] = ascii_digit(row_dec.units);
                pos              = pos + 3'd1;
                seq_d.bytes[pos] = 8'h3B;
                pos              = pos + 3'd1;
                if (col_dec.tens != 4'd0) begin
                    seq_d.bytes[pos] = ascii_digit(col_dec.tens);
                    pos              = pos + 3'd1;
                end
                seq_d.bytes[pos] = ascii_digit(col_dec.units);
                pos              = pos + 3'd1;
                seq_d.bytes[pos] = 8'h48;
                seq_d.len        = {1'b0, pos} + 4'd1;
            end
            OP_CLEAR: begin
                seq_d.bytes[0] = ESC;
                seq_d.bytes[1] = 8'h5B;
                seq_d.bytes[2] = 8'h32;
                seq_d.bytes[3] = 8'h4A;
                seq_d.bytes[4] = ESC;
                seq_d.bytes[5] = 8'h5B;
                seq_d.bytes[6] = 8'h48;
                seq_d.len      = 4'd7;
            end
            default: begin
                seq_d.bytes[0] = ESC;
                seq_d.bytes[1] = 8'h5B;
                seq_d.bytes[2] = 8'h33;
                seq_d.bytes[3] = ascii_digit({1'b0, cmd_fg});
                seq_d.bytes[4] = 8'h6D;
                seq_d.len      = 4'd5;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // LOAD stages the following byte while the current one is still on the wire.
    always_comb begin
        state_d   = state_q;
        uart_load = 1'b0;
        uart_byte = nxt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    uart_load = 1'b1;
                    uart_byte = seq_d.bytes[0];
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: begin
                if (uart_done) begin
                    if (idx_q == seq_q.len) begin
                        state_d = ST_IDLE;
                    end else begin
                        uart_load = 1'b1;
                        state_d   = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q <= '0;
            idx_q <= 4'd0;
            nxt_q <= 8'h00;
        end else if (accept) begin
            seq_q <= seq_d;
            idx_q <= 4'd1;
        end else if (state_q == ST_LOAD) begin
            nxt_q <= seq_q.bytes[idx_q[2:0]];
        end else if ((state_q == ST_SEND) && uart_done && (idx_q != seq_q.len)) begin
            idx_q <= idx_q + 4'd1;
        end
    end

    vt100_uart_tx #(
        .DIV (DIV)
    ) u_uart (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_vld (uart_load),
        .byte_dat (uart_byte),
        .done     (uart_done),
        .tx       (tx)
    );

endmodule

// File: tb/tb_vt100_tx.sv
// Directed bench for vt100_tx at DIV=10: a UART receiver model decodes tx, steps check bytes and timing.
module tb_vt100_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_char;
    logic [4:0] cmd_row;
    logic [6:0] cmd_col;
    logic [2:0] cmd_fg;
    logic       tx;
    logic       busy;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         stop_bad = 0;
    logic [7:0] exp_q[$];

    bit         mon_act = 1'b0;
    int         mon_cnt;
    int         mon_start;
    logic [7:0] mon_sh;

    vt100_tx #(
        .CLOCK_FREQ (1000000),
        .BAUD_RATE  (100000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_char  (cmd_char),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .cmd_fg    (cmd_fg),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver: start detected at the first low sample, data sampled mid-bit.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act   = 1'b1;
                mon_cnt   = 0;
                mon_start = cyc;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt >= 14 && mon_cnt <= 84 && ((mon_cnt - 4) % 10) == 0)
                mon_sh[(mon_cnt - 14) / 10] = tx;
            if (mon_cnt == 94) begin
                if (tx !== 1'b1) stop_bad++;
                rx_q.push_back(mon_sh);
                rx_t.push_back(mon_start);
            end
            if (mon_cnt == 99) mon_act = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] ch, input logic [4:0] row,
                         input logic [6:0] col, input logic [2:0] fg);
        cmd_op    = op;
        cmd_char  = ch;
        cmd_row   = row;
        cmd_col   = col;
        cmd_fg    = fg;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_char  = ~ch;
        cmd_row   = ~row;
        cmd_col   = ~col;
        cmd_fg    = ~fg;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_rx(input string tag, input int brk);
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        end
        for (int i = 1; i < rx_t.size(); i++) begin
            chk($sformatf("%s_gap%0d", tag, i), rx_t[i] - rx_t[i-1], (i == brk) ? 101 : 100);
        end
        chk({tag, "_stop"}, stop_bad, 0);
        rx_q.delete();
        rx_t.delete();
    endtask

    initial begin
        #200us;
        $error("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         zeros;
        logic [9:0] frame;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_char  = 8'h00;
        cmd_row   = 5'd0;
        cmd_col   = 7'd0;
        cmd_fg    = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", tx, 1);
        chk("reset_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // CHAR 'A': exact frame, bit by bit
        frame = {1'b1, 8'h41, 1'b0};
        issue(2'd0, 8'h41, 5'd0, 7'd0, 3'd0);
        chk("char_busy", busy, 1);
        for (int k = 0; k < 100; k++) begin
            chk($sformatf("char_tx_rdy_c%0d", k), {tx, cmd_ready}, {frame[k/10], 1'b0});
            @(posedge clk);
            #1;
        end
        chk("char_ready_after", cmd_ready, 1);
        chk("char_busy_after", busy, 0);
        exp_q = '{8'h41};
        check_rx("char", -1);

        issue(2'd1, 8'h00, 5'd4, 7'd11, 3'd0);
        wait_ready(n);
        chk("goto_ready_low", n, 700);
        exp_q = '{8'h1B, 8'h5B, 8'h35, 8'h3B, 8'h31, 8'h32, 8'h48};
        check_rx("goto", -1);

        issue(2'd1, 8'h00, 5'd31, 7'd100, 3'd0);
        wait_ready(n);
        chk("clamp_ready_low", n, 800);
        exp_q = '{8'h1B, 8'h5B, 8'h33, 8'h30, 8'h3B, 8'h38, 8'h30, 8'h48};
        check_rx("clamp", -1);

        // CLEAR then COLOR with cmd_valid held high across both
        cmd_op    = 2'd2;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_op = 2'd3;
        cmd_fg = 3'd2;
        wait_ready(n);
        chk("clear_ready_low", n, 700);
        chk("idle_gap_tx", tx, 1);
        @(posedge clk);
        #1;
        chk("color_accepted", cmd_ready, 0);
        cmd_valid = 1'b0;
        wait_ready(n);
        chk("color_ready_low", n, 500);
        exp_q = '{8'h1B, 8'h5B, 8'h32, 8'h4A, 8'h1B, 8'h5B, 8'h48,
                  8'h1B, 8'h5B, 8'h33, 8'h32, 8'h6D};
        check_rx("clr_col", 7);

        // Reset mid data bit 2 of the second CLEAR byte (0x5B, bit 2 is 0)
        issue(2'd2, 8'h00, 5'd0, 7'd0, 3'd0);
        repeat (135) @(posedge clk);
        #1;
        chk("pre_reset_tx", tx, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_tx", tx, 1);
        chk("arst_ready", cmd_ready, 1);
        chk("arst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        zeros = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) zeros++;
        end
        chk("abort_tx_low_cycles", zeros, 0);
        exp_q = '{8'h1B};
        check_rx("abort", -1);

        issue(2'd0, 8'h5A, 5'd0, 7'd0, 3'd0);
        wait_ready(n);
        chk("post_reset_ready_low", n, 100);
        exp_q = '{8'h5A};
        check_rx("post_reset", -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
